mem_io_ctrl: RTL and testbench

Memory and I/O responder on the CPU's byte-wide memory bus: the target end of the bus the CPU drives. It owns the main RAM and the memory-mapped I/O port at 0x30000. It buffers UART receive and transmit bytes in FIFOs and serves a free-running cycle counter. It sits between the CPU and the UART/host-interface logic, and drives the CPU's ready input to throttle writes.

---
 rtl/mem_io_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mem_io_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_ctrl.sv
// CPU memory-bus target: byte RAM, rx/tx byte FIFOs, cycle counter and stop flag at 0x30000.
// Read data one cycle after the address edge; rdy_out throttles the CPU before the tx FIFO can overflow.

module mem_io_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Storage is never cleared, so mask the head to zero when nothing is queued.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module mem_io_ctrl #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        rdy_out,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        prog_stop
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] TX_LIMIT = (PW+1)'(FIFO_DEPTH - 1);

  logic [7:0]            ram [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  is_io;
  logic [2:0]            io_sel;
  logic                  bus_rd;
  logic                  bus_wr;
  logic [31:0]           cyc_cnt;
  logic [31:0]           snap;
  logic [7:0]            rd_byte;
  logic                  addr_hi_unused;

  logic [7:0]  rx_head;
  logic [PW:0] rx_cnt_unused;
  logic        rx_empty;
  logic        rx_full;
  logic        rx_pop;

  logic [PW:0] tx_count;
  logic        tx_empty;
  logic        tx_full_unused;
  logic        tx_push;
  logic [7:0]  tx_push_dat;

  assign addr_hi_unused = |mem_a[31:18];
  assign ram_idx = mem_a[ADDR_WIDTH-1:0];
  assign is_io   = (mem_a[17:16] == 2'b11);
  assign io_sel  = mem_a[2:0];
  assign bus_rd  = rdy_out && !mem_wr;
  assign bus_wr  = rdy_out && mem_wr;

  // Leaving one slot free means the write taken in the last ready cycle always fits.
  assign rdy_out  = (tx_count < TX_LIMIT);
  assign rx_ready = !rx_full;
  assign tx_valid = !tx_empty;

  assign rx_pop      = bus_rd && is_io && (io_sel == 3'd0) && !rx_empty;
  assign tx_push     = bus_wr && is_io &&
                       (((io_sel == 3'd0) && (mem_dout != 8'h00)) || (io_sel == 3'd4));
  assign tx_push_dat = (io_sel == 3'd4) ? 8'h00 : mem_dout;

  always_comb begin
    rd_byte = 8'h00;
    if (!is_io) begin
      rd_byte = ram[ram_idx];
    end else begin
      case (io_sel)
        3'd0:    rd_byte = rx_head;
        3'd4:    rd_byte = cyc_cnt[7:0];
        3'd5:    rd_byte = snap[15:8];
        3'd6:    rd_byte = snap[23:16];
        3'd7:    rd_byte = snap[31:24];
        default: rd_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (bus_wr && !is_io) ram[ram_idx] <= mem_dout;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_din   <= 8'h00;
      cyc_cnt   <= 32'h0;
      snap      <= 32'h0;
      prog_stop <= 1'b0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'h1;
      if (bus_rd) mem_din <= rd_byte;
      if (bus_rd && is_io && (io_sel == 3'd4)) snap <= cyc_cnt;
      if (bus_wr && is_io && (io_sel == 3'd4)) prog_stop <= 1'b1;
    end
  end

  mem_io_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .push     (rx_valid && rx_ready),
    .push_dat (rx_data),
    .pop      (rx_pop),
    .head     (rx_head),
    .count    (rx_cnt_unused),
    .empty    (rx_empty),
    .full     (rx_full)
  );

  mem_io_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .push     (tx_push),
    .push_dat (tx_push_dat),
    .pop      (tx_valid && tx_ready),
    .head     (tx_data),
    .count    (tx_count),
    .empty    (tx_empty),
    .full     (tx_full_unused)
  );
endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed bench for mem_io_ctrl: vector table for single-cycle behaviour, hand sequences for counter,
// tx back-pressure and asynchronous reset.
module tb_mem_io_ctrl;
  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [31:0] mem_a = 32'h30003;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = 8'h00;
  logic [7:0]  mem_din;
  logic        rdy_out;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        prog_stop;

  mem_io_ctrl #(.ADDR_WIDTH(17), .FIFO_DEPTH(16)) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .mem_a     (mem_a),
    .mem_wr    (mem_wr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .rdy_out   (rdy_out),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .prog_stop (prog_stop)
  );

  always #5 clk_in = ~clk_in;

  // Reference cycle counter: value the DUT counter holds between edges.
  logic [31:0] m_cnt;
  always @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) m_cnt <= 32'h0;
    else           m_cnt <= m_cnt + 32'h1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [7:0]  d;
    logic        rxv;
    logic [7:0]  rxd;
    logic        txr;
    logic [7:0]  e_din;
    logic        e_txv;
    logic [7:0]  e_txd;
    logic        e_stop;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [7:0] d,
                              input logic rxv, input logic [7:0] rxd, input logic [7:0] e_din,
                              input logic e_txv, input logic [7:0] e_txd, input logic e_stop);
    vec_t v;
    v.wr = wr; v.a = a; v.d = d; v.rxv = rxv; v.rxd = rxd; v.txr = 1'b1;
    v.e_din = e_din; v.e_txv = e_txv; v.e_txd = e_txd; v.e_stop = e_stop;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus(input logic wr, input logic [31:0] a, input logic [7:0] d);
    mem_wr = wr; mem_a = a; mem_dout = d;
  endtask

  initial begin
    logic [31:0] exp_cnt;

    // Reset values before any edge
    #3;
    chk("rst din", mem_din, 8'h00);
    chk("rst tx_valid", tx_valid, 1'b0);
    chk("rst tx_data", tx_data, 8'h00);
    chk("rst rx_ready", rx_ready, 1'b1);
    chk("rst rdy_out", rdy_out, 1'b1);
    chk("rst prog_stop", prog_stop, 1'b0);
    #14 rst_n_in = 1'b1;

    //            wr    addr        d     rxv   rxd    din    txv   txd    stop
    tbl.push_back(mk(1, 32'h00010, 8'hA5, 0, 8'h00, 8'h00, 0, 8'h00, 0));
    tbl.push_back(mk(0, 32'h00010, 8'h00, 0, 8'h00, 8'hA5, 0, 8'h00, 0));
    tbl.push_back(mk(0, 32'h20010, 8'h00, 0, 8'h00, 8'hA5, 0, 8'h00, 0));
    tbl.push_back(mk(1, 32'h00011, 8'h3C, 0, 8'h00, 8'hA5, 0, 8'h00, 0));
    tbl.push_back(mk(0, 32'h00011, 8'h00, 0, 8'h00, 8'h3C, 0, 8'h00, 0));
    tbl.push_back(mk(0, 32'h30003, 8'h00, 1, 8'h41, 8'h00, 0, 8'h00, 0));
    tbl.push_back(mk(0, 32'h30003, 8'h00, 1, 8'h42, 8'h00, 0, 8'h00, 0));
    tbl.push_back(mk(0, 32'h30000, 8'h00, 0, 8'h00, 8'h41, 0, 8'h00, 0));
    tbl.push_back(mk(0, 32'h30000, 8'h00, 0, 8'h00, 8'h42, 0, 8'h00, 0));
    tbl.push_back(mk(0, 32'h30000, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 0));
    tbl.push_back(mk(0, 32'h30000, 8'h00, 1, 8'h43, 8'h00, 0, 8'h00, 0));
    tbl.push_back(mk(0, 32'h30000, 8'h00, 0, 8'h00, 8'h43, 0, 8'h00, 0));
    tbl.push_back(mk(1, 32'h30000, 8'h00, 0, 8'h00, 8'h43, 0, 8'h00, 0));
    tbl.push_back(mk(1, 32'h30001, 8'h55, 0, 8'h00, 8'h43, 0, 8'h00, 0));
    tbl.push_back(mk(1, 32'h30000, 8'h5A, 0, 8'h00, 8'h43, 1, 8'h5A, 0));
    tbl.push_back(mk(0, 32'h30003, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 0));
    tbl.push_back(mk(1, 32'h30004, 8'h77, 0, 8'h00, 8'h00, 1, 8'h00, 1));
    tbl.push_back(mk(0, 32'h30003, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(0, 32'h30003, 8'h00, 1, 8'h61, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(0, 32'h30000, 8'h00, 1, 8'h62, 8'h61, 0, 8'h00, 1));
    tbl.push_back(mk(0, 32'h30000, 8'h00, 0, 8'h00, 8'h62, 0, 8'h00, 1));
    tbl.push_back(mk(0, 32'h30000, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 1));
    tbl.push_back(mk(0, 32'h30006, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 1));

    foreach (tbl[i]) begin
      bus(tbl[i].wr, tbl[i].a, tbl[i].d);
      rx_valid = tbl[i].rxv; rx_data = tbl[i].rxd; tx_ready = tbl[i].txr;
      cyc();
      rx_valid = 1'b0;
      chk($sformatf("v%0d din", i), mem_din, tbl[i].e_din);
      chk($sformatf("v%0d tx_valid", i), tx_valid, tbl[i].e_txv);
      if (tbl[i].e_txv) chk($sformatf("v%0d tx_data", i), tx_data, tbl[i].e_txd);
      chk($sformatf("v%0d prog_stop", i), prog_stop, tbl[i].e_stop);
      chk($sformatf("v%0d rdy_out", i), rdy_out, 1'b1);
      chk($sformatf("v%0d rx_ready", i), rx_ready, 1'b1);
    end

    // Counter snapshot straddling a byte-1 carry (0x2FE -> 0x300)
    bus(0, 32'h30003, 8'h00);
    for (int k = 0; k < 2000 && m_cnt != 32'h2FE; k++) cyc();
    if (m_cnt != 32'h2FE) begin
      n_chk++; n_fail++;
      $display("FAIL cnt_wait: counter never reached 0x2fe, at 0x%0h", m_cnt);
    end
    bus(0, 32'h30004, 8'h00); cyc(); chk("cnt b0", mem_din, 8'hFE);
    bus(0, 32'h30005, 8'h00); cyc(); chk("cnt b1", mem_din, 8'h02);
    bus(0, 32'h30006, 8'h00); cyc(); chk("cnt b2", mem_din, 8'h00);
    bus(0, 32'h30007, 8'h00); cyc(); chk("cnt b3", mem_din, 8'h00);
    bus(0, 32'h30003, 8'h00); cyc(); cyc(); cyc();
    bus(0, 32'h30005, 8'h00); cyc(); chk("cnt b1 held", mem_din, 8'h02);
    exp_cnt = m_cnt;
    bus(0, 32'h30004, 8'h00); cyc(); chk("cnt b0 again", mem_din, exp_cnt[7:0]);
    bus(0, 32'h30005, 8'h00); cyc(); chk("cnt b1 again", mem_din, exp_cnt[15:8]);

    // tx back-pressure with a pending rx byte that must not be popped while stalled
    tx_ready = 1'b0;
    bus(0, 32'h30003, 8'h00); rx_valid = 1'b1; rx_data = 8'h71; cyc(); rx_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      bus(1, 32'h30000, 8'(8'h10 + i));
      cyc();
      chk($sformatf("bp rdy w%0d", i), rdy_out, (i < 14) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      bus(1, 32'h30000, 8'hEE);
      cyc();
      chk($sformatf("bp hold%0d", i), rdy_out, 1'b0);
    end
    bus(0, 32'h30000, 8'h00); cyc();
    chk("bp stalled read", mem_din, 8'h00);
    bus(0, 32'h30003, 8'h00); tx_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("drain vld%0d", k), tx_valid, 1'b1);
      chk($sformatf("drain dat%0d", k), tx_data, 8'(8'h10 + k));
      cyc();
      if (k == 0) chk("drain rdy back", rdy_out, 1'b1);
    end
    chk("drain empty", tx_valid, 1'b0);
    chk("drain rdy", rdy_out, 1'b1);
    bus(0, 32'h30000, 8'h00); cyc(); chk("rx after stall", mem_din, 8'h71);

    // Async reset with both FIFOs occupied and non-zero read data
    tx_ready = 1'b0;
    bus(1, 32'h30000, 8'h99); cyc();
    bus(0, 32'h00010, 8'h00);
    for (int i = 0; i < 16; i++) begin
      rx_valid = 1'b1; rx_data = 8'(8'h80 + i); cyc();
    end
    rx_valid = 1'b0;
    chk("pre rst rx_ready", rx_ready, 1'b0);
    chk("pre rst tx_valid", tx_valid, 1'b1);
    chk("pre rst din", mem_din, 8'hA5);
    #2 rst_n_in = 1'b0;
    #1;
    chk("arst tx_valid", tx_valid, 1'b0);
    chk("arst tx_data", tx_data, 8'h00);
    chk("arst rx_ready", rx_ready, 1'b1);
    chk("arst din", mem_din, 8'h00);
    chk("arst rdy_out", rdy_out, 1'b1);
    chk("arst prog_stop", prog_stop, 1'b0);
    @(negedge clk_in); #1 rst_n_in = 1'b1;
    tx_ready = 1'b1;
    bus(0, 32'h30004, 8'h00); cyc(); chk("post rst cnt", mem_din, 8'h00);
    bus(0, 32'h30000, 8'h00); cyc(); chk("post rst rx empty", mem_din, 8'h00);
    chk("post rst tx_valid", tx_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
